// File: rtl/li_expander.sv
// Expands a 32-bit constant load into an RV32I LUI/ADDI pair, one instruction per handshake.
// The single-instruction forms are chosen at accept time, so each emit state only walks forward.
module li_expander #(
    parameter bit ZERO_OPT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_const,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_EMIT_LUI  = 2'd1;
    localparam logic [1:0] S_EMIT_ADDI = 2'd2;

    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [11:0] r_lo12;
    logic [4:0]  r_rd;
    logic [31:0] r_instr;
    logic        r_last;

    logic [19:0] w_hi20;
    logic [11:0] w_lo12;
    logic        w_accept;
    logic        w_emit_done;

    // Adding 0x800 only ever carries into bit 12 when bit 11 is set; the 20-bit add drops bit 32.
    assign w_hi20      = in_const[31:12] + {19'd0, in_const[11]};
    assign w_lo12      = in_const[11:0];
    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state != S_IDLE);
    assign out_instr   = r_instr;
    assign out_last    = r_last;
    assign w_accept    = in_valid && in_ready;
    assign w_emit_done = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lo12  <= 12'd0;
            r_rd    <= 5'd0;
            r_instr <= 32'd0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lo12 <= w_lo12;
                        r_rd   <= in_rd;
                        if (in_rd == 5'd0) begin
                            r_state <= S_EMIT_ADDI;
                            r_instr <= NOP;
                            r_last  <= 1'b1;
                        end else if (ZERO_OPT && (w_hi20 == 20'd0)) begin
                            r_state <= S_EMIT_ADDI;
                            r_instr <= {w_lo12, 5'd0, 3'b000, in_rd, OP_ADDI};
                            r_last  <= 1'b1;
                        end else if (ZERO_OPT && (w_lo12 == 12'd0)) begin
                            r_state <= S_EMIT_LUI;
                            r_instr <= {w_hi20, in_rd, OP_LUI};
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= S_EMIT_LUI;
                            r_instr <= {w_hi20, in_rd, OP_LUI};
                            r_last  <= 1'b0;
                        end
                    end
                end
                S_EMIT_LUI, S_EMIT_ADDI: begin
                    if (w_emit_done) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_instr <= 32'd0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= S_EMIT_ADDI;
                            r_instr <= {r_lo12, r_rd, 3'b000, r_rd, OP_ADDI};
                            r_last  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_instr <= 32'd0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
